alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares the single combinational RV32 integer ALU between two requesters (requester 0: execute stage; requester 1: address/auxiliary unit) using valid/ready handshakes. Round-robin grant, one operation in flight, registered operands and result. Sits in front of the ALU's operandA/operandB/funct3/funct7 inputs and captures its result.

## Interface
- TAG_W, default 4: width of the requester-supplied tag echoed on the response.
- clk  in  1  rising-edge clock, only clock domain
- rst  in  1  synchronous, active-high reset
- req_valid_0 / req_valid_1  in  1  operation request
- req_ready_0 / req_ready_1  out  1  request accepted this cycle when valid & ready
- req_a_0 / req_a_1  in  32  operand A
- req_b_0 / req_b_1  in  32  operand B
- req_funct3_0 / req_funct3_1  in  3  ALU operation selector
- req_funct7_0 / req_funct7_1  in  1  ALU sub-operation selector (sub / arithmetic shift)
- req_tag_0 / req_tag_1  in  TAG_W  opaque tag
- rsp_valid_0 / rsp_valid_1  out  1  result available for that requester
- rsp_ready_0 / rsp_ready_1  in  1  requester consumes result
- rsp_result  out  32  result (shared, qualified by rsp_valid_x)
- rsp_tag  out  TAG_W  tag of the completed request
- rsp_err  out  1  funct3 was 3'b110 or 3'b111 (result forced to 0)
- alu_operand_a, alu_operand_b  out  32  to ALU operandA/operandB
- alu_funct3  out  3,  alu_funct7  out  1  to ALU selectors
- alu_result  in  32  from ALU result

## Operation
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: grant = highest-priority valid requester; prio pointer selects which wins when both valid. req_ready_k = (state==IDLE) & grant_k; at most one ready high. On handshake: latch a, b, funct3, funct7, tag, owner id; pointer set to the other requester; go EXEC.
- EXEC (1 cycle): ALU driven from latched registers; at clock edge capture alu_result into result register (or 0 with rsp_err=1 if funct3 ∈ {110,111}); go RESP.
- RESP: rsp_valid_owner=1, other rsp_valid=0; rsp_result/rsp_tag/rsp_err stable until rsp_ready_owner=1, then IDLE. rsp_ready of non-owner ignored.
- alu_* outputs always reflect latched registers (hold last op outside EXEC).
- Supported ops (ALU encoding): 000 add (f7=0) / sub (f7=1); 001 sll by b; 101 srl (f7=0) / sra (f7=1); 010 and; 011 or; 100 xor. Arithmetic mod 2^32, no overflow flag.
- Requester must hold valid and payload stable until ready; valid must not depend on ready; ready may depend on valid.

## Timing
- Reset: state=IDLE, pointer=requester 0, all latched registers 0, all rsp_valid 0, rsp_result 0, rsp_tag 0, rsp_err 0, req_ready 0 during the reset cycle.
- Latency: handshake at edge N -> rsp_valid high from N+2. Minimum throughput one op per 3 cycles (next req_ready in the cycle after the rsp handshake).
- Simultaneous valid_0 & valid_1: pointer winner granted; loser waits, wins next arbitration if still valid.
- Single valid: granted regardless of pointer; pointer still flips to the other requester.
- Back-pressure: RESP holds indefinitely; no new request accepted.
- rst mid-EXEC/RESP: operation discarded, no response, IDLE next cycle.

## Test plan
- Reset, then req0 add a=0x0000_0005 b=0x0000_0003 tag=2 -> req_ready_0 same cycle, rsp_valid_0 two cycles later, rsp_result=0x8, rsp_tag=2, rsp_err=0.
- Both valid continuously after reset: req0 sub 0x10-0x20, req1 sra 0x8000_0000>>4 -> grants alternate 0,1,0,…; results 0xFFFF_FFF0 and 0xF800_0000.
- req1 funct3=110 -> rsp_result=0, rsp_err=1; funct3=101 f7=0 on 0x8000_0000>>4 -> 0x0800_0000.
- Hold rsp_ready_0=0 for 10 cycles -> rsp_valid_0, result, tag stable; req_ready_1 stays 0 though req_valid_1=1; accepted the cycle after rsp_ready_0 pulse.
- Assert rst during EXEC -> no rsp_valid ever for that op; next req0 granted (pointer reset).
- Wrap: add 0xFFFF_FFFF+1 -> 0x0; sll 0x1 by 31 -> 0x8000_0000.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_share_arbiter.
// master = requesters plus the external ALU; slave = the arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned TAG_W = 4
);
  logic             req_valid_0;
  logic             req_valid_1;
  logic             req_ready_0;
  logic             req_ready_1;
  logic [31:0]      req_a_0;
  logic [31:0]      req_a_1;
  logic [31:0]      req_b_0;
  logic [31:0]      req_b_1;
  logic [2:0]       req_funct3_0;
  logic [2:0]       req_funct3_1;
  logic             req_funct7_0;
  logic             req_funct7_1;
  logic [TAG_W-1:0] req_tag_0;
  logic [TAG_W-1:0] req_tag_1;
  logic             rsp_valid_0;
  logic             rsp_valid_1;
  logic             rsp_ready_0;
  logic             rsp_ready_1;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic [31:0]      alu_operand_a;
  logic [31:0]      alu_operand_b;
  logic [2:0]       alu_funct3;
  logic             alu_funct7;
  logic [31:0]      alu_result;

  modport master (
    output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
           req_funct3_0, req_funct3_1, req_funct7_0, req_funct7_1,
           req_tag_0, req_tag_1, rsp_ready_0, rsp_ready_1, alu_result,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
           rsp_result, rsp_tag, rsp_err,
           alu_operand_a, alu_operand_b, alu_funct3, alu_funct7
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
           req_funct3_0, req_funct3_1, req_funct7_0, req_funct7_1,
           req_tag_0, req_tag_1, rsp_ready_0, rsp_ready_1, alu_result,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
           rsp_result, rsp_tag, rsp_err,
           alu_operand_a, alu_operand_b, alu_funct3, alu_funct7
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational RV32 ALU between two requesters;
// one operation in flight, operands and result registered.
module alu_share_arbiter #(
  parameter int unsigned TAG_W = 4
) (
  input logic                clk,
  input logic                rst,
  alu_share_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       f3_q, f3_d;
  logic             f7_q, f7_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      result_q, result_d;
  logic             err_q, err_d;

  logic grant_0, grant_1, op_err, rsp_ack;

  always_comb begin
    // ptr_q names the requester that wins a tie; a lone requester always wins
    grant_0 = bus.req_valid_0 & (~bus.req_valid_1 | ~ptr_q);
    grant_1 = bus.req_valid_1 & (~bus.req_valid_0 | ptr_q);
    op_err  = (f3_q[2:1] == 2'b11);
    rsp_ack = owner_q ? bus.rsp_ready_1 : bus.rsp_ready_0;

    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    f3_d     = f3_q;
    f7_d     = f7_q;
    tag_d    = tag_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (grant_0 | grant_1) begin
          a_d     = grant_1 ? bus.req_a_1      : bus.req_a_0;
          b_d     = grant_1 ? bus.req_b_1      : bus.req_b_0;
          f3_d    = grant_1 ? bus.req_funct3_1 : bus.req_funct3_0;
          f7_d    = grant_1 ? bus.req_funct7_1 : bus.req_funct7_0;
          tag_d   = grant_1 ? bus.req_tag_1    : bus.req_tag_0;
          owner_d = grant_1;
          ptr_d   = ~grant_1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = op_err ? '0 : bus.alu_result;
        err_d    = op_err;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      f7_q     <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      f7_q     <= f7_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Ready is masked during reset so nothing is accepted in the reset cycle
  assign bus.req_ready_0   = ~rst & (state_q == S_IDLE) & grant_0;
  assign bus.req_ready_1   = ~rst & (state_q == S_IDLE) & grant_1;
  assign bus.rsp_valid_0   = (state_q == S_RESP) & ~owner_q;
  assign bus.rsp_valid_1   = (state_q == S_RESP) & owner_q;
  assign bus.rsp_result    = result_q;
  assign bus.rsp_tag       = tag_q;
  assign bus.rsp_err       = err_q;
  assign bus.alu_operand_a = a_q;
  assign bus.alu_operand_b = b_q;
  assign bus.alu_funct3    = f3_q;
  assign bus.alu_funct7    = f7_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; the external ALU is modelled here.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.TAG_W(4)) bus ();

  alu_share_arbiter #(.TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External ALU; unsupported selectors return a marker the arbiter must mask
  always_comb begin
    case (bus.alu_funct3)
      3'b000:  bus.alu_result = bus.alu_funct7 ? bus.alu_operand_a - bus.alu_operand_b
                                               : bus.alu_operand_a + bus.alu_operand_b;
      3'b001:  bus.alu_result = bus.alu_operand_a << bus.alu_operand_b[4:0];
      3'b101:  bus.alu_result = bus.alu_funct7
                 ? 32'($signed(bus.alu_operand_a) >>> bus.alu_operand_b[4:0])
                 : bus.alu_operand_a >> bus.alu_operand_b[4:0];
      3'b010:  bus.alu_result = bus.alu_operand_a & bus.alu_operand_b;
      3'b011:  bus.alu_result = bus.alu_operand_a | bus.alu_operand_b;
      3'b100:  bus.alu_result = bus.alu_operand_a ^ bus.alu_operand_b;
      default: bus.alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? bus.req_ready_0 : bus.req_ready_1;
  endfunction

  function automatic logic rv(input int k);
    return (k == 0) ? bus.rsp_valid_0 : bus.rsp_valid_1;
  endfunction

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic f7, input logic [3:0] tag);
    if (k == 0) begin
      bus.req_a_0 = a; bus.req_b_0 = b; bus.req_funct3_0 = f3;
      bus.req_funct7_0 = f7; bus.req_tag_0 = tag; bus.req_valid_0 = 1'b1;
    end else begin
      bus.req_a_1 = a; bus.req_b_1 = b; bus.req_funct3_1 = f3;
      bus.req_funct7_1 = f7; bus.req_tag_1 = tag; bus.req_valid_1 = 1'b1;
    end
  endtask

  task automatic drop_req(input int k);
    if (k == 0) bus.req_valid_0 = 1'b0;
    else        bus.req_valid_1 = 1'b0;
  endtask

  // Present a request, expect ready in the same cycle, complete the handshake
  task automatic send(input int k, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f3, input logic f7, input logic [3:0] tag);
    int unsigned cnt = 0;
    set_req(k, a, b, f3, f7, tag);
    @(negedge clk);
    while (!rdy(k) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("grant_wait", cnt, 0);
    chk("req_ready", 32'(rdy(k)), 1);
    @(posedge clk); #1;
    drop_req(k);
  endtask

  // Called just after the handshake edge; checks latency, payload, hold, then acks
  task automatic wait_rsp(input int k, input logic [31:0] exp_res, input logic [3:0] exp_tag,
                          input logic exp_err, input int unsigned hold);
    int unsigned cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!rv(k) && cnt < 20);
    chk("rsp_latency", cnt, 2);
    chk("rsp_result", bus.rsp_result, exp_res);
    chk("rsp_tag", 32'(bus.rsp_tag), 32'(exp_tag));
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    chk("rsp_other_valid", 32'(rv(1 - k)), 0);
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rv(k)), 1);
      chk("hold_result", bus.rsp_result, exp_res);
      chk("hold_tag", 32'(bus.rsp_tag), 32'(exp_tag));
      chk("hold_ready_1", 32'(bus.req_ready_1), 0);
    end
    if (k == 0) bus.rsp_ready_0 = 1'b1; else bus.rsp_ready_1 = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_0 = 1'b0;
    bus.rsp_ready_1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
    bus.rsp_ready_0 = 1'b0; bus.rsp_ready_1 = 1'b0;
    bus.req_a_0 = '0; bus.req_b_0 = '0; bus.req_funct3_0 = '0; bus.req_funct7_0 = 1'b0; bus.req_tag_0 = '0;
    bus.req_a_1 = '0; bus.req_b_1 = '0; bus.req_funct3_1 = '0; bus.req_funct7_1 = 1'b0; bus.req_tag_1 = '0;

    // Reset state, with a request pending that must not be accepted
    @(posedge clk); #1;
    set_req(0, 32'h1, 32'h1, 3'b000, 1'b0, 4'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_ready_0", 32'(bus.req_ready_0), 0);
    chk("rst_rsp_valid_0", 32'(bus.rsp_valid_0), 0);
    chk("rst_rsp_valid_1", 32'(bus.rsp_valid_1), 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_tag", 32'(bus.rsp_tag), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_alu_a", bus.alu_operand_a, 0);
    chk("rst_alu_b", bus.alu_operand_b, 0);
    drop_req(0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic add
    send(0, 32'h5, 32'h3, 3'b000, 1'b0, 4'h2);
    chk("alu_a_latched", bus.alu_operand_a, 32'h5);
    wait_rsp(0, 32'h8, 4'h2, 1'b0, 0);

    // Both valid continuously: grants alternate 0,1,0,1
    do_reset();
    set_req(0, 32'h10, 32'h20, 3'b000, 1'b1, 4'h1);
    set_req(1, 32'h8000_0000, 32'h4, 3'b101, 1'b1, 4'h5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_ready_0", 32'(bus.req_ready_0), 32'((i % 2) == 0));
      chk("alt_ready_1", 32'(bus.req_ready_1), 32'((i % 2) == 1));
      @(posedge clk); #1;
      if ((i % 2) == 0) wait_rsp(0, 32'hFFFF_FFF0, 4'h1, 1'b0, 0);
      else              wait_rsp(1, 32'hF800_0000, 4'h5, 1'b0, 0);
    end
    drop_req(0);
    drop_req(1);

    // Unsupported selector, then logical shift right
    send(1, 32'h1234_5678, 32'h1, 3'b110, 1'b0, 4'h7);
    wait_rsp(1, 32'h0, 4'h7, 1'b1, 0);
    send(1, 32'h1, 32'h1, 3'b111, 1'b1, 4'h8);
    wait_rsp(1, 32'h0, 4'h8, 1'b1, 0);
    send(1, 32'h8000_0000, 32'h4, 3'b101, 1'b0, 4'h9);
    wait_rsp(1, 32'h0800_0000, 4'h9, 1'b0, 0);

    // Back-pressure: response held 10 cycles, requester 1 blocked meanwhile
    send(0, 32'h7, 32'h9, 3'b000, 1'b0, 4'h3);
    set_req(1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, 1'b0, 4'h9);
    wait_rsp(0, 32'h10, 4'h3, 1'b0, 10);
    @(negedge clk);
    chk("bp_ready_1_after", 32'(bus.req_ready_1), 1);
    @(posedge clk); #1;
    drop_req(1);
    wait_rsp(1, 32'hFF00_FF00, 4'h9, 1'b0, 0);

    // Reset during EXEC discards the op and returns the pointer to requester 0
    send(0, 32'h1, 32'h2, 3'b000, 1'b0, 4'hA);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_exec_no_rsp", 32'({bus.rsp_valid_1, bus.rsp_valid_0}), 0);
    end
    set_req(0, 32'h0F0, 32'h00F, 3'b011, 1'b0, 4'h4);
    set_req(1, 32'hFF00, 32'h0FF0, 3'b010, 1'b0, 4'h6);
    #1;
    chk("rst_ptr_ready_0", 32'(bus.req_ready_0), 1);
    chk("rst_ptr_ready_1", 32'(bus.req_ready_1), 0);
    @(posedge clk); #1;
    drop_req(0);
    wait_rsp(0, 32'h0FF, 4'h4, 1'b0, 0);
    @(negedge clk);
    chk("rst_then_ready_1", 32'(bus.req_ready_1), 1);
    @(posedge clk); #1;
    drop_req(1);
    wait_rsp(1, 32'h0F00, 4'h6, 1'b0, 0);

    // Wrap-around boundaries
    send(0, 32'hFFFF_FFFF, 32'h1, 3'b000, 1'b0, 4'hB);
    wait_rsp(0, 32'h0, 4'hB, 1'b0, 0);
    send(1, 32'h1, 32'd31, 3'b001, 1'b0, 4'hC);
    wait_rsp(1, 32'h8000_0000, 4'hC, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
